csi_capture_ctrl: RTL and testbench
===================================

# csi_capture_ctrl

Sequences packet capture behind the power trigger in the CSI extractor. Arming fills a pre-trigger delay line; the block then waits for a rising edge on the power-trigger output. It emits a fixed-length window of samples that starts PRETRIG_LEN samples before the trigger, and then either re-arms after a holdoff or returns to idle. The sample stream feeds the downstream CSI/FFT datapath, which applies no backpressure.

## Interface
- PRETRIG_LEN, 16, pre-trigger depth in valid samples; power of two, minimum 2.
- clk_in  in  1  clock.
- rst_n_in  in  1  reset; one clock, asynchronous and active-low.
- arm_in  in  1  single-cycle arm request; honoured only in IDLE.
- continuous_in  in  1  1 = re-arm after holdoff; sampled on the last-sample cycle.
- capture_len_in  in  16  window length in samples; latched at trigger; 0 is treated as 1.
- holdoff_len_in  in  16  valid samples to wait after a window; latched at window end.
- trigger_in  in  1  level from power_trigger.
- signal_data_in  in  32  I/Q sample; I in [15:0], Q in [31:16].
- signal_valid_in  in  1  sample strobe.
- capture_data_out  out  32  delayed sample.
- capture_valid_out  out  1  sample strobe.
- capture_last_out  out  1  final sample of the window.
- done_out  out  1  one-cycle pulse, coincident with capture_last_out.
- busy_out  out  1  high in every state except IDLE.
- pkt_count_out  out  16  windows completed; wraps modulo 2^16.

## Operation
- **Delay line:** PRETRIG_LEN x 32 circular buffer with write pointer wr_ptr.
  - Every valid sample is written at wr_ptr, in every state.
  - The word read at wr_ptr before the overwrite is the sample from exactly PRETRIG_LEN valid samples earlier.
  - wr_ptr wraps naturally at PRETRIG_LEN.
- **Edge detect:** trig_prev updates only on valid cycles. A rise is a valid cycle with trigger_in=1 and trig_prev=0.
- **IDLE:**
  - arm_in -> FILL.
  - Clears fill_cnt.
- **FILL:**
  - fill_cnt counts valid samples.
  - The valid cycle on which fill_cnt reaches PRETRIG_LEN-1 -> ARMED.
  - That cycle's sample is the PRETRIG_LEN-th sample after arm.
- **ARMED:**
  - A rise -> CAPTURE.
  - Latches len = max(capture_len_in, 1).
  - Emits the delayed sample for this cycle as window sample 1.
  - Sets cnt=1.
  - If len==1, applies the end-of-window rule on this same cycle.
- **CAPTURE:** each valid cycle emits one delayed sample and increments cnt.
- **End of window** (the valid cycle where cnt reaches len):
  - capture_last_out=1 and done_out=1.
  - pkt_count_out increments.
  - If continuous_in=1, go to HOLDOFF and clear the holdoff counter; otherwise go to IDLE.
- **HOLDOFF:**
  - Counts valid samples.
  - Once holdoff_len_in samples have been counted -> ARMED.
  - holdoff_len_in=0 means ARMED on the next cycle, with no sample needed.
  - A trigger still high on entry to ARMED does not fire; a fresh rise is required.
- **Ignored inputs:**
  - arm_in outside IDLE has no effect.
  - A trigger rise outside ARMED has no effect.
- Sample emission is in stream order with no gaps or duplicates; output valid mirrors input valid during the window.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - All counters, wr_ptr and trig_prev clear.
  - All outputs are 0, including pkt_count_out and capture_data_out.
  - Buffer contents are undefined; FILL guarantees they are never emitted before being written.
- **Reset mid-window:** the window is truncated with no last/done; capture_valid_out is 0 from the reset edge.
- **Output latency:** all outputs are registered; a sample accepted on edge k appears after edge k, for one cycle.
- capture_valid_out and capture_last_out are 0 on non-valid cycles.
- **busy_out** is registered:
  - It is 1 from the cycle after arm.
  - It returns to 0 the cycle after the last sample when not continuous.
- **Input gaps:** signal_valid_in may idle arbitrarily between samples; counters advance only on valid cycles.
- **Simultaneous events:**
  - A rise on the same cycle as the FILL->ARMED transition does not trigger.
  - arm_in on the end-of-window cycle is ignored.

## Configuration
- **CSI_CAPTURE_STATS_EN defined:** the pkt_count_out counter is implemented as described above.
- **CSI_CAPTURE_STATS_EN undefined:** pkt_count_out is tied to 0 and no counter logic is built; all other behaviour is identical.

## Test plan
- **Basic window.** Setup: PRETRIG_LEN=16, input data = running index 0,1,2,..., valid every cycle, arm at sample 0, trigger rises at sample 40, capture_len_in=8. Required response: outputs are samples 24..31, last/done on sample 31, busy returns to 0 afterwards, pkt_count_out=1.
- **Gapped valid.** Setup: valid 1-in-3 cycles, otherwise as the basic window. Required response: the same 8 samples with no duplicates, and valid only on accepted cycles.
- **Continuous re-arm.** Setup: continuous_in=1, holdoff_len_in=10, trigger held high through the holdoff, then dropped and re-raised at sample 80. Required response: the second window starts at sample 64, and pkt_count_out reaches 2.
- **Degenerate lengths.** Stimulus: capture_len_in=0. Required response: a single sample with valid, last and done on the same cycle. Stimulus: holdoff_len_in=0. Required response: ARMED one cycle after the end of the window.
- **Early or ignored trigger.** Stimulus: a trigger rise during FILL at sample 5. Required response: no output. Stimulus: arm_in during CAPTURE. Required response: no effect.
- **Reset mid-window.** Stimulus: rst_n_in low for 1 cycle at window sample 3 of 8. Required response: all outputs are 0 immediately and the state is IDLE; a re-arm works normally, and pkt_count_out=0 (the stats build is the only one that can show a non-zero count).

Source files
------------

// File: rtl/csi_capture_ctrl.sv
// csi_capture_ctrl
//   Sequences packet capture behind the power trigger. Arming fills a
//   PRETRIG_LEN-deep delay line. A rising trigger edge in ARMED then emits a
//   window of capture_len_in samples that starts PRETRIG_LEN samples before the
//   trigger. After the window the block either re-arms after a holdoff
//   (continuous_in=1) or returns to idle.
//
// Build option:
//   CSI_CAPTURE_STATS_EN  defined   -> pkt_count_out counts completed windows
//                         undefined -> pkt_count_out tied to 0, no counter built
//
// Ports:
//   clk_in, rst_n_in       clock, async active-low reset
//   arm_in                 arm request (IDLE only)
//   continuous_in          re-arm after holdoff, sampled on the last-sample cycle
//   capture_len_in         window length (latched at trigger, 0 -> 1)
//   holdoff_len_in         holdoff in valid samples (latched at window end)
//   trigger_in             power-trigger level
//   signal_data_in/valid   input sample stream
//   capture_data_out/valid delayed sample stream during the window
//   capture_last_out       final window sample
//   done_out               pulse with capture_last_out
//   busy_out               high outside IDLE
//   pkt_count_out          completed windows (mod 2^16)
//
// state     | meaning
// S_IDLE    | waiting for arm_in
// S_FILL    | refilling the delay line after arm
// S_ARMED   | waiting for a trigger rise
// S_CAPTURE | emitting window samples
// S_HOLDOFF | counting holdoff samples before re-arming
module csi_capture_ctrl #(
  parameter int PRETRIG_LEN = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        arm_in,
  input  logic        continuous_in,
  input  logic [15:0] capture_len_in,
  input  logic [15:0] holdoff_len_in,
  input  logic        trigger_in,
  input  logic [31:0] signal_data_in,
  input  logic        signal_valid_in,
  output logic [31:0] capture_data_out,
  output logic        capture_valid_out,
  output logic        capture_last_out,
  output logic        done_out,
  output logic        busy_out,
  output logic [15:0] pkt_count_out
);

  localparam int AW = $clog2(PRETRIG_LEN);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_CAPTURE, S_HOLDOFF} state_t;

  state_t        state;
  logic [31:0]   mem [PRETRIG_LEN];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fill_cnt;
  logic          trig_prev;
  logic [15:0]   len_q;
  logic [15:0]   cnt;
  logic [15:0]   hold_len_q;
  logic [15:0]   hold_cnt;

  logic [31:0]   delayed;
  logic [15:0]   len_eff;
  logic          rise;
  logic          fire;
  logic          cap_step;
  logic          win_end;

  // Read-before-write: the slot about to be overwritten holds the sample
  // from exactly PRETRIG_LEN valid samples ago.
  assign delayed  = mem[wr_ptr];
  assign len_eff  = (capture_len_in == 16'd0) ? 16'd1 : capture_len_in;
  assign rise     = signal_valid_in & trigger_in & ~trig_prev;
  assign fire     = (state == S_ARMED) && rise;
  assign cap_step = (state == S_CAPTURE) && signal_valid_in;
  assign win_end  = (fire && (len_eff == 16'd1)) ||
                    (cap_step && ((cnt + 16'd1) == len_q));

  // Delay line storage carries no reset; FILL rewrites every slot before use.
  always_ff @(posedge clk_in) begin
    if (signal_valid_in) mem[wr_ptr] <= signal_data_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= S_IDLE;
      wr_ptr            <= '0;
      fill_cnt          <= '0;
      trig_prev         <= 1'b0;
      len_q             <= 16'd0;
      cnt               <= 16'd0;
      hold_len_q        <= 16'd0;
      hold_cnt          <= 16'd0;
      capture_data_out  <= 32'd0;
      capture_valid_out <= 1'b0;
      capture_last_out  <= 1'b0;
      done_out          <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      capture_valid_out <= 1'b0;
      capture_last_out  <= 1'b0;
      done_out          <= 1'b0;
      capture_data_out  <= 32'd0;

      if (signal_valid_in) begin
        wr_ptr    <= wr_ptr + AW'(1);
        trig_prev <= trigger_in;
      end

      if (fire || cap_step) begin
        capture_valid_out <= 1'b1;
        capture_data_out  <= delayed;
      end

      case (state)
        S_IDLE: begin
          fill_cnt <= '0;
          if (arm_in) begin
            state    <= S_FILL;
            busy_out <= 1'b1;
          end
        end
        S_FILL: begin
          if (signal_valid_in) begin
            if (fill_cnt == AW'(PRETRIG_LEN - 1)) state <= S_ARMED;
            else                                  fill_cnt <= fill_cnt + AW'(1);
          end
        end
        S_ARMED: begin
          if (fire) begin
            len_q <= len_eff;
            cnt   <= 16'd1;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cap_step) cnt <= cnt + 16'd1;
        end
        S_HOLDOFF: begin
          if (hold_len_q == 16'd0) begin
            state <= S_ARMED;
          end else if (signal_valid_in) begin
            hold_cnt <= hold_cnt + 16'd1;
            if (hold_cnt == (hold_len_q - 16'd1)) state <= S_ARMED;
          end
        end
        default: state <= S_IDLE;
      endcase

      // End of window overrides the per-state next state (covers len==1 in ARMED).
      if (win_end) begin
        capture_last_out <= 1'b1;
        done_out         <= 1'b1;
        if (continuous_in) begin
          state      <= S_HOLDOFF;
          hold_cnt   <= 16'd0;
          hold_len_q <= holdoff_len_in;
        end else begin
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end
      end
    end
  end

`ifdef CSI_CAPTURE_STATS_EN
  logic [15:0] pkt_count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)    pkt_count <= 16'd0;
    else if (win_end) pkt_count <= pkt_count + 16'd1;
  end

  assign pkt_count_out = pkt_count;
`else
  assign pkt_count_out = 16'd0;
`endif

endmodule

// File: tb/tb_csi_capture_ctrl.sv
// Directed bench for csi_capture_ctrl: expected window samples are queued when
// the trigger stimulus is driven and popped as the DUT emits them.
module tb_csi_capture_ctrl;
  localparam int P = 16;

`ifdef CSI_CAPTURE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        arm_in;
  logic        continuous_in;
  logic [15:0] capture_len_in;
  logic [15:0] holdoff_len_in;
  logic        trigger_in;
  logic [31:0] signal_data_in;
  logic        signal_valid_in;
  logic [31:0] capture_data_out;
  logic        capture_valid_out;
  logic        capture_last_out;
  logic        done_out;
  logic        busy_out;
  logic [15:0] pkt_count_out;

  csi_capture_ctrl #(.PRETRIG_LEN(P)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .arm_in            (arm_in),
    .continuous_in     (continuous_in),
    .capture_len_in    (capture_len_in),
    .holdoff_len_in    (holdoff_len_in),
    .trigger_in        (trigger_in),
    .signal_data_in    (signal_data_in),
    .signal_valid_in   (signal_valid_in),
    .capture_data_out  (capture_data_out),
    .capture_valid_out (capture_valid_out),
    .capture_last_out  (capture_last_out),
    .done_out          (done_out),
    .busy_out          (busy_out),
    .pkt_count_out     (pkt_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   idx      = 0;
  int   exp_pkt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input logic v_applied);
    exp_t e;
    if (capture_valid_out === 1'b1) begin
      chk("valid_on_accepted_cycle", {31'd0, v_applied}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sample_data", capture_data_out, e.data);
        chk("sample_last", {31'd0, capture_last_out}, {31'd0, e.last});
        chk("sample_done", {31'd0, done_out}, {31'd0, e.last});
      end
    end else begin
      chk("idle_last_done", {30'd0, capture_last_out, done_out}, 32'd0);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs checked on the next.
  task automatic step(input logic v, input logic trig, input logic arm);
    signal_valid_in = v;
    trigger_in      = trig;
    arm_in          = arm;
    signal_data_in  = 32'(idx);
    @(posedge clk_in);
    @(negedge clk_in);
    if (v) idx++;
    arm_in = 1'b0;
    check_out(v);
  endtask

  task automatic run_to(input int last_idx, input logic trig, input int gap);
    while (idx <= last_idx) begin
      step(1'b1, trig, 1'b0);
      repeat (gap) step(1'b0, trig, 1'b0);
    end
  endtask

  task automatic push_window(input int start, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.data = 32'(start + i);
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic window_done(input string tag, input int n_windows);
    chk({tag, "_all_emitted"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy_out}, 32'd0);
    exp_pkt += n_windows * STATS;
    chk({tag, "_pkt_count"}, {16'd0, pkt_count_out}, 32'(exp_pkt));
  endtask

  initial begin
    rst_n_in        = 1'b0;
    arm_in          = 1'b0;
    continuous_in   = 1'b0;
    capture_len_in  = 16'd8;
    holdoff_len_in  = 16'd0;
    trigger_in      = 1'b0;
    signal_data_in  = 32'd0;
    signal_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_valid", {31'd0, capture_valid_out}, 32'd0);
    chk("reset_busy", {31'd0, busy_out}, 32'd0);
    chk("reset_data", capture_data_out, 32'd0);
    chk("reset_pkt", {16'd0, pkt_count_out}, 32'd0);
    rst_n_in = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Basic window
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    chk("basic_busy_after_arm", {31'd0, busy_out}, 32'd1);
    run_to(39, 1'b0, 0);
    chk("basic_busy_armed", {31'd0, busy_out}, 32'd1);
    push_window(24, 8);
    run_to(50, 1'b1, 0);
    window_done("basic", 1);
    run_to(55, 1'b0, 0);

    // Gapped valid, 1-in-3
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    run_to(39, 1'b0, 2);
    push_window(24, 8);
    run_to(50, 1'b1, 2);
    window_done("gapped", 1);
    run_to(55, 1'b0, 2);

    // Trigger rise during FILL is ignored; arm during CAPTURE is ignored
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    run_to(4, 1'b0, 0);
    run_to(9, 1'b1, 0);
    run_to(39, 1'b0, 0);
    push_window(24, 8);
    run_to(42, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1);
    run_to(50, 1'b1, 0);
    window_done("ignored", 1);
    run_to(55, 1'b0, 0);

    // Continuous re-arm with holdoff 10, trigger held high through holdoff
    continuous_in  = 1'b1;
    holdoff_len_in = 16'd10;
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    run_to(39, 1'b0, 0);
    push_window(24, 8);
    run_to(50, 1'b1, 0);
    chk("cont_busy_holdoff", {31'd0, busy_out}, 32'd1);
    chk("cont_first_emitted", 32'(exp_q.size()), 32'd0);
    run_to(69, 1'b1, 0);
    continuous_in = 1'b0;
    run_to(79, 1'b0, 0);
    push_window(64, 8);
    run_to(90, 1'b1, 0);
    window_done("continuous", 2);
    run_to(95, 1'b0, 0);

    // capture_len_in = 0 behaves as a single-sample window
    capture_len_in = 16'd0;
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    run_to(39, 1'b0, 0);
    push_window(24, 1);
    run_to(45, 1'b1, 0);
    window_done("len_zero", 1);
    run_to(50, 1'b0, 0);

    // holdoff_len_in = 0: ARMED on the cycle after window end
    capture_len_in = 16'd2;
    holdoff_len_in = 16'd0;
    continuous_in  = 1'b1;
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    run_to(39, 1'b0, 0);
    push_window(24, 2);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    push_window(27, 2);
    continuous_in = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_to(50, 1'b0, 0);
    window_done("holdoff_zero", 2);

    // Reset at window sample 3 of 8
    capture_len_in = 16'd8;
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    run_to(39, 1'b0, 0);
    push_window(24, 8);
    run_to(41, 1'b1, 0);
    chk("rst_two_emitted", 32'(exp_q.size()), 32'd6);
    signal_valid_in = 1'b1;
    rst_n_in = 1'b0;
    #1;
    chk("rst_valid", {31'd0, capture_valid_out}, 32'd0);
    chk("rst_last_done", {30'd0, capture_last_out, done_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_data", capture_data_out, 32'd0);
    chk("rst_pkt", {16'd0, pkt_count_out}, 32'd0);
    exp_q.delete();
    exp_pkt = 0;
    signal_valid_in = 1'b0;
    trigger_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("rst_idle_busy", {31'd0, busy_out}, 32'd0);
    idx = 0;
    step(1'b1, 1'b0, 1'b1);
    run_to(39, 1'b0, 0);
    push_window(24, 8);
    run_to(50, 1'b1, 0);
    window_done("after_reset", 1);
    run_to(55, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
